// File: rtl/adau1761_spi_responder.sv
// ADAU1761 control-port SPI slave backing a local register window.
// Oversampled SPI (CPOL=0, CPHA=0), lock sequence, auto-increment, write strobe to fabric.
`default_nettype none

module adau1761_spi_responder #(
  parameter logic [15:0] BASE_ADDR = 16'h4000,
  parameter int          DEPTH     = 256,
  parameter int          LOCK_CNT  = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        spi_locked,
  output logic        wr_strobe,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;

  typedef enum logic [2:0] {
    S_UNLOCKED = 3'd0,
    S_IDLE     = 3'd1,
    S_CMD      = 3'd2,
    S_ADDR_HI  = 3'd3,
    S_ADDR_LO  = 3'd4,
    S_DATA     = 3'd5
  } state_t;

  logic [2:0]    sclk_sync_q, cs_sync_q;
  logic [1:0]    mosi_sync_q;
  state_t        state_q, state_d;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          locked_q, locked_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    rx_q, rx_d;
  logic [7:0]    tx_q, tx_d;
  logic          rnw_q, rnw_d;
  logic [15:0]   addr_q, addr_d;
  logic          load_pend_q, load_pend_d;
  logic          oe_q, oe_d;
  logic          strobe_q, strobe_d;
  logic [15:0]   wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          mem_we;
  logic [7:0]    mem_q [DEPTH];

  logic          sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [7:0]    rx_byte;
  logic [15:0]   offset;
  logic          in_win;
  logic [AW-1:0] idx;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];
  assign rx_byte   = {rx_q[6:0], mosi_sync_q[1]};
  // 16-bit subtraction wraps, so addresses below BASE_ADDR land far out of range
  assign offset    = addr_q - BASE_ADDR;
  assign in_win    = ({1'b0, offset} < 17'(DEPTH));
  assign idx       = offset[AW-1:0];

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    locked_d    = locked_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    load_pend_d = load_pend_q;
    strobe_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we      = 1'b0;
    if (state_q == S_UNLOCKED) begin
      if (cs_rise) begin
        if (lock_cnt_q == LW'(LOCK_CNT - 1)) begin
          locked_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + LW'(1);
        end
      end
    end else if (cs_rise) begin
      state_d = S_IDLE;
    end else if (cs_fall) begin
      state_d     = S_CMD;
      bit_cnt_d   = 3'd0;
      load_pend_d = 1'b0;
      tx_d        = 8'h00;
    end else if (state_q != S_IDLE) begin
      if (sclk_rise) begin
        rx_d      = rx_byte;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            S_CMD: begin
              rnw_d   = rx_byte[0];
              state_d = S_ADDR_HI;
            end
            S_ADDR_HI: begin
              addr_d[15:8] = rx_byte;
              state_d      = S_ADDR_LO;
            end
            S_ADDR_LO: begin
              addr_d[7:0] = rx_byte;
              state_d     = S_DATA;
              load_pend_d = 1'b1;
            end
            S_DATA: begin
              if (!rnw_q && in_win) begin
                mem_we    = 1'b1;
                strobe_d  = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = rx_byte;
              end
              addr_d      = addr_q + 16'd1;
              load_pend_d = 1'b1;
            end
            default: ;
          endcase
        end
      end else if (sclk_fall && state_q == S_DATA && rnw_q) begin
        // first falling edge of each byte loads; the remaining seven shift
        if (load_pend_q) begin
          tx_d        = in_win ? mem_q[idx] : 8'h00;
          load_pend_d = 1'b0;
        end else begin
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
    end
    oe_d = (state_d == S_DATA) && rnw_d;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sclk_sync_q <= 3'b000;
      cs_sync_q   <= 3'b111;
      mosi_sync_q <= 2'b00;
      state_q     <= S_UNLOCKED;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
      bit_cnt_q   <= 3'd0;
      rx_q        <= 8'h00;
      tx_q        <= 8'h00;
      rnw_q       <= 1'b0;
      addr_q      <= 16'h0000;
      load_pend_q <= 1'b0;
      oe_q        <= 1'b0;
      strobe_q    <= 1'b0;
      wr_addr_q   <= 16'h0000;
      wr_data_q   <= 8'h00;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[1:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      load_pend_q <= load_pend_d;
      oe_q        <= oe_d;
      strobe_q    <= strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      if (mem_we) mem_q[idx] <= rx_byte;
    end
  end

  assign spi_miso    = oe_q & tx_q[7];
  assign spi_miso_oe = oe_q;
  assign spi_locked  = locked_q;
  assign wr_strobe   = strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

endmodule

`default_nettype wire

// File: tb/tb_adau1761_spi_responder.sv
// Directed bench for adau1761_spi_responder: lock, write, read, burst, abort, bounds, relock.
`default_nettype none

module tb_adau1761_spi_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe, spi_locked, wr_strobe;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mo [16];
  logic        mi_bit [128];
  logic        oe_bit [128];
  logic [15:0] st_addr [16];
  logic [7:0]  st_data [16];
  int          st_n = 0;

  adau1761_spi_responder #(.BASE_ADDR(16'h4000), .DEPTH(256), .LOCK_CNT(3)) dut (
    .clk(clk), .resetn(resetn), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .spi_locked(spi_locked), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe && st_n < 16) begin
      st_addr[st_n] = wr_addr;
      st_data[st_n] = wr_data;
      st_n = st_n + 1;
    end
  end

  // stimulus moves only on multiples of 10 ns, i.e. on clk falling edges
  task automatic spi_frame(input int nbits);
    spi_cs_n = 1'b0;
    #80;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[i / 8][7 - (i % 8)];
      #40;
      mi_bit[i] = spi_miso;
      oe_bit[i] = spi_miso_oe;
      spi_sclk = 1'b1;
      #40;
      spi_sclk = 1'b0;
    end
    #80;
    spi_cs_n = 1'b1;
    #120;
  endtask

  task automatic cs_pulse();
    spi_cs_n = 1'b0;
    #80;
    spi_cs_n = 1'b1;
    #120;
  endtask

  function automatic logic [7:0] mi_byte(input int k);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[7 - j] = mi_bit[k * 8 + j];
    return b;
  endfunction

  task automatic set_hdr(input logic [7:0] c, input logic [7:0] ah, input logic [7:0] al);
    mo[0] = c; mo[1] = ah; mo[2] = al;
  endtask

  task automatic test_reset();
    resetn = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({spi_miso, spi_miso_oe, spi_locked, wr_strobe} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got miso/oe/locked/strobe=%b expected 0000",
               {spi_miso, spi_miso_oe, spi_locked, wr_strobe});
    end
    checks++;
    if (wr_addr !== 16'h0000 || wr_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_wr_bus got %h/%h expected 0000/00", wr_addr, wr_data);
    end
    resetn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_lock();
    st_n = 0;
    set_hdr(8'h00, 8'h40, 8'h00); mo[3] = 8'h05;
    spi_frame(32);
    checks++;
    if (st_n !== 0 || spi_locked !== 1'b0) begin
      errors++;
      $display("FAIL prelock_frame got strobes=%0d locked=%b expected 0/0", st_n, spi_locked);
    end
    cs_pulse();
    checks++;
    if (spi_locked !== 1'b0) begin
      errors++;
      $display("FAIL lock_after_2 got %b expected 0", spi_locked);
    end
    cs_pulse();
    checks++;
    if (spi_locked !== 1'b1) begin
      errors++;
      $display("FAIL lock_after_3 got %b expected 1", spi_locked);
    end
    set_hdr(8'h01, 8'h40, 8'h00); mo[3] = 8'h00;
    spi_frame(32);
    checks++;
    if (mi_byte(3) !== 8'h00) begin
      errors++;
      $display("FAIL lock_mem0 got %h expected 00", mi_byte(3));
    end
  endtask

  task automatic test_write();
    st_n = 0;
    set_hdr(8'h00, 8'h40, 8'h00); mo[3] = 8'h01;
    spi_frame(32);
    checks++;
    if (st_n !== 1 || st_addr[0] !== 16'h4000 || st_data[0] !== 8'h01) begin
      errors++;
      $display("FAIL write_strobe got n=%0d %h/%h expected 1 4000/01", st_n, st_addr[0], st_data[0]);
    end
  endtask

  task automatic test_read();
    logic oe_addr, oe_data;
    st_n = 0;
    set_hdr(8'h01, 8'h40, 8'h00); mo[3] = 8'h00;
    spi_frame(32);
    oe_addr = 1'b0; oe_data = 1'b1;
    for (int i = 0; i < 24; i++) oe_addr = oe_addr | oe_bit[i];
    for (int i = 24; i < 32; i++) oe_data = oe_data & oe_bit[i];
    checks++;
    if (mi_byte(3) !== 8'h01) begin
      errors++;
      $display("FAIL read_data got %h expected 01", mi_byte(3));
    end
    checks++;
    if (oe_addr !== 1'b0 || oe_data !== 1'b1) begin
      errors++;
      $display("FAIL read_oe got hdr=%b data=%b expected 0/1", oe_addr, oe_data);
    end
    checks++;
    if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0 || st_n !== 0) begin
      errors++;
      $display("FAIL read_end got oe=%b miso=%b strobes=%0d expected 0/0/0",
               spi_miso_oe, spi_miso, st_n);
    end
  endtask

  task automatic test_burst();
    st_n = 0;
    set_hdr(8'h00, 8'h40, 8'h10); mo[3] = 8'hAA; mo[4] = 8'hBB; mo[5] = 8'hCC;
    spi_frame(48);
    checks++;
    if (st_n !== 3 || st_addr[0] !== 16'h4010 || st_data[0] !== 8'hAA ||
        st_addr[1] !== 16'h4011 || st_data[1] !== 8'hBB ||
        st_addr[2] !== 16'h4012 || st_data[2] !== 8'hCC) begin
      errors++;
      $display("FAIL burst_strobes got n=%0d %h/%h %h/%h %h/%h expected 3 4010/aa 4011/bb 4012/cc",
               st_n, st_addr[0], st_data[0], st_addr[1], st_data[1], st_addr[2], st_data[2]);
    end
    set_hdr(8'h01, 8'h40, 8'h10);
    spi_frame(48);
    checks++;
    if (mi_byte(3) !== 8'hAA || mi_byte(4) !== 8'hBB || mi_byte(5) !== 8'hCC) begin
      errors++;
      $display("FAIL burst_read got %h %h %h expected aa bb cc", mi_byte(3), mi_byte(4), mi_byte(5));
    end
  endtask

  task automatic test_abort();
    st_n = 0;
    set_hdr(8'h00, 8'h40, 8'h20); mo[3] = 8'hFF;
    spi_frame(29);
    checks++;
    if (st_n !== 0 || spi_miso_oe !== 1'b0) begin
      errors++;
      $display("FAIL abort_partial got strobes=%0d oe=%b expected 0/0", st_n, spi_miso_oe);
    end
    set_hdr(8'h00, 8'h40, 8'h20); mo[3] = 8'h5A;
    spi_frame(32);
    checks++;
    if (st_n !== 1 || st_addr[0] !== 16'h4020 || st_data[0] !== 8'h5A) begin
      errors++;
      $display("FAIL abort_next got n=%0d %h/%h expected 1 4020/5a", st_n, st_addr[0], st_data[0]);
    end
  endtask

  task automatic test_bounds();
    st_n = 0;
    set_hdr(8'h00, 8'h3F, 8'hFF); mo[3] = 8'h11; mo[4] = 8'h22;
    spi_frame(40);
    checks++;
    if (st_n !== 1 || st_addr[0] !== 16'h4000 || st_data[0] !== 8'h22) begin
      errors++;
      $display("FAIL bounds_low got n=%0d %h/%h expected 1 4000/22", st_n, st_addr[0], st_data[0]);
    end
    set_hdr(8'h01, 8'h41, 8'h00); mo[3] = 8'h00;
    spi_frame(32);
    checks++;
    if (mi_byte(3) !== 8'h00) begin
      errors++;
      $display("FAIL bounds_high_read got %h expected 00", mi_byte(3));
    end
    st_n = 0;
    set_hdr(8'h00, 8'hFF, 8'hFF); mo[3] = 8'h33; mo[4] = 8'h44;
    spi_frame(40);
    checks++;
    if (st_n !== 0) begin
      errors++;
      $display("FAIL bounds_wrap got strobes=%0d expected 0", st_n);
    end
    set_hdr(8'h01, 8'h40, 8'h00); mo[3] = 8'h00;
    spi_frame(32);
    checks++;
    if (mi_byte(3) !== 8'h22) begin
      errors++;
      $display("FAIL bounds_mem0 got %h expected 22", mi_byte(3));
    end
  endtask

  task automatic test_relock();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (spi_locked !== 1'b0) begin
      errors++;
      $display("FAIL relock_reset got %b expected 0", spi_locked);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    st_n = 0;
    set_hdr(8'h00, 8'h40, 8'h00); mo[3] = 8'h77;
    spi_frame(32);
    checks++;
    if (st_n !== 0 || spi_locked !== 1'b0) begin
      errors++;
      $display("FAIL relock_ignored got strobes=%0d locked=%b expected 0/0", st_n, spi_locked);
    end
    cs_pulse();
    cs_pulse();
    set_hdr(8'h01, 8'h40, 8'h10); mo[3] = 8'h00;
    spi_frame(32);
    checks++;
    if (spi_locked !== 1'b1 || mi_byte(3) !== 8'h00) begin
      errors++;
      $display("FAIL relock_cleared got locked=%b data=%h expected 1/00", spi_locked, mi_byte(3));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mo[i] = 8'h00;
    test_reset();
    test_lock();
    test_write();
    test_read();
    test_burst();
    test_abort();
    test_bounds();
    test_relock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
